clk_edge_monitor: RTL
=====================

CLK_EDGE_MONITOR -- requirements
Module: clk_edge_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-002 Parameter TIMEOUT, default 28'd130000000: number of MCLK cycles with no rising edge before the clock is declared lost.
REQ-003 Parameter FILT_LEN, default 4: number of stable samples required by the glitch filter (used only when the filter is compiled in).
REQ-004 MCLK  input  1  system clock (50 MHz); all state updates on its rising edge.
REQ-005 RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 CLOCK_IN  input  1  slow divided clock; may be asynchronous to MCLK.
REQ-007 TICK_RISE  output  1  one-MCLK-cycle pulse per accepted rising edge of CLOCK_IN.
REQ-008 TICK_FALL  output  1  one-MCLK-cycle pulse per accepted falling edge of CLOCK_IN.
REQ-009 PERIOD  output  28  MCLK-cycle count between the last two accepted rising edges.
REQ-010 PERIOD_VALID  output  1  high when PERIOD holds a complete measurement.
REQ-011 CLK_LOST  output  1  high while the monitor is in state LOST.

Function
REQ-012 CLOCK_IN SHALL pass through a SYNC_STAGES flop chain, followed by one history flop used for edge detection.
REQ-013 An accepted edge SHALL assert TICK_RISE or TICK_FALL exactly SYNC_STAGES+1 MCLK cycles after the first MCLK edge that samples the new level.
REQ-014 TICK_RISE and TICK_FALL SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per edge.
REQ-015 A 28-bit counter SHALL increment every cycle, be cleared to 1 on an accepted rising edge, and saturate at its maximum value.
REQ-016 The FSM SHALL have four states: IDLE, ARMED, LOCKED and LOST.
REQ-017 IDLE: on the first rising edge, go to ARMED (no PERIOD update).
REQ-018 ARMED: on a rising edge, load PERIOD with the counter value, set PERIOD_VALID and go to LOCKED.
REQ-019 LOCKED: on each rising edge, reload PERIOD with the counter value.
REQ-020 In ARMED or LOCKED, if the counter reaches TIMEOUT with no rising edge, the FSM SHALL go to LOST and clear PERIOD_VALID; PERIOD holds its last value.
REQ-021 LOST: on a rising edge, go to ARMED and clear the counter to 1; CLK_LOST falls in that same cycle.
REQ-022 A rising edge in the same cycle the counter reaches TIMEOUT SHALL count as an edge: no transition to LOST.
REQ-023 IDLE SHALL never time out; CLK_LOST SHALL stay 0 until at least one edge has been seen.
REQ-024 A falling edge SHALL only pulse TICK_FALL and SHALL NOT affect the counter or the FSM.

Reset
REQ-025 RESET_N low SHALL immediately force: all sync flops 0, history flop 0, counter 0, PERIOD 0, PERIOD_VALID 0, TICK_RISE 0, TICK_FALL 0, CLK_LOST 0, FSM IDLE.
REQ-026 Reset asserted mid-measurement SHALL discard the measurement; after release, the first rising edge only arms the FSM.
REQ-027 CLOCK_IN already high at reset release SHALL produce one TICK_RISE (the history flop resets to 0).

Configuration
REQ-028 Macro CLK_MON_GLITCH_FILTER_EN defined: a synchronized level change SHALL be accepted only after FILT_LEN consecutive equal samples, which adds FILT_LEN-1 cycles to the REQ-013 latency; shorter pulses produce no tick.
REQ-029 Macro CLK_MON_GLITCH_FILTER_EN undefined: no filter logic is present and every synchronized transition is accepted.

Structure
REQ-030 Shared package tlc_pkg SHALL hold the FSM state enum (IDLE, ARMED, LOCKED, LOST), the 28-bit counter width constant and the default TIMEOUT.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_ff, parameterized by SYNC_STAGES.

Verification (test parameters: TIMEOUT=20, FILT_LEN=3, SYNC_STAGES=2)
REQ-032 CLOCK_IN square wave with 10-cycle period -> first TICK_RISE 3 cycles after the first high sample; PERIOD=10 and PERIOD_VALID=1 after the second rise.
REQ-033 CLOCK_IN held low after LOCKED -> CLK_LOST=1 and PERIOD_VALID=0 exactly 20 cycles after the last counter clear; PERIOD stays 10.
REQ-034 Rising edge arriving on the cycle the counter reaches 20 -> CLK_LOST stays 0 and PERIOD=20.
REQ-035 RESET_N pulsed low mid-period while CLOCK_IN is high -> all outputs 0 at once; one TICK_RISE after release; PERIOD_VALID only after two further rises.
REQ-036 Filter enabled, 2-cycle high glitch -> no TICK_RISE; 3-cycle high pulse -> TICK_RISE at latency 5.
REQ-037 Glitch filter disabled, 1-cycle-wide pulse sampled once -> exactly one TICK_RISE followed by one TICK_FALL.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the clock edge monitor.
//   CNT_W           : width of the period counter and PERIOD output
//   TIMEOUT_DEFAULT : default loss-of-clock timeout in MCLK cycles
//   tlc_state_e     : monitor FSM states
package tlc_pkg;

    localparam int unsigned CNT_W = 28;

    localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 28'd130000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } tlc_state_e;

endpackage

// File: rtl/clk_edge_monitor_if.sv
// Monitored-clock bundle: the slow clock going in and the measurement results coming out.
//   CLOCK_IN     : slow clock under observation (may be asynchronous to MCLK)
//   TICK_RISE    : one-cycle pulse per accepted rising edge
//   TICK_FALL    : one-cycle pulse per accepted falling edge
//   PERIOD       : MCLK cycles between the last two accepted rising edges
//   PERIOD_VALID : PERIOD holds a complete measurement
//   CLK_LOST     : monitored clock has timed out
// master drives CLOCK_IN and observes results; slave is the monitor itself.
interface clk_edge_monitor_if;

    logic                       CLOCK_IN;
    logic                       TICK_RISE;
    logic                       TICK_FALL;
    logic [tlc_pkg::CNT_W-1:0]  PERIOD;
    logic                       PERIOD_VALID;
    logic                       CLK_LOST;

    modport master (
        output CLOCK_IN,
        input  TICK_RISE,
        input  TICK_FALL,
        input  PERIOD,
        input  PERIOD_VALID,
        input  CLK_LOST
    );

    modport slave (
        input  CLOCK_IN,
        output TICK_RISE,
        output TICK_FALL,
        output PERIOD,
        output PERIOD_VALID,
        output CLK_LOST
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk, rst_n : clock and asynchronous active-low reset (chain clears to 0)
//   d_i        : asynchronous input level
//   q_o        : synchronized level, SYNC_STAGES cycles behind d_i
module sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the new sample in at bit 0; the oldest sample leaves at the top.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_edge_monitor.sv
// Clock edge monitor: synchronizes a slow clock, emits rise/fall ticks, measures
// the rising-edge period in MCLK cycles and flags loss of clock after TIMEOUT cycles.
//   MCLK, RESET_N : system clock and asynchronous active-low reset
//   mon (slave)   : CLOCK_IN in; TICK_RISE, TICK_FALL, PERIOD, PERIOD_VALID, CLK_LOST out
// Build option: define CLK_MON_GLITCH_FILTER_EN to require FILT_LEN consecutive equal
// synchronized samples before a level change is accepted.
module clk_edge_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int unsigned      FILT_LEN    = 4
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    clk_edge_monitor_if.slave mon
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1) begin : g_bad_param
        $error("clk_edge_monitor: SYNC_STAGES must be 2..4 and FILT_LEN at least 1");
    end

    logic             sync_lvl;
    logic             rise_c;
    logic             fall_c;
    logic             rise_q;
    logic             fall_q;

    tlc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_fall_q, tick_fall_d;

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (MCLK),
        .rst_n (RESET_N),
        .d_i   (mon.CLOCK_IN),
        .q_o   (sync_lvl)
    );

`ifdef CLK_MON_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic              lvl_q, lvl_d;
    logic [FILT_W-1:0] fcnt_q, fcnt_d;

    // lvl_q is the accepted level and doubles as the edge-detect history;
    // any sample matching it restarts the run of differing samples.
    always_comb begin
        lvl_d  = lvl_q;
        fcnt_d = '0;
        rise_c = 1'b0;
        fall_c = 1'b0;
        if (sync_lvl != lvl_q) begin
            if (fcnt_q == FILT_W'(FILT_LEN - 1)) begin
                lvl_d  = sync_lvl;
                rise_c = sync_lvl;
                fall_c = ~sync_lvl;
            end else begin
                fcnt_d = fcnt_q + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lvl_q  <= 1'b0;
            fcnt_q <= '0;
        end else begin
            lvl_q  <= lvl_d;
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic hist_q;

    // Every synchronized transition is an accepted edge.
    assign rise_c = sync_lvl & ~hist_q;
    assign fall_c = ~sync_lvl & hist_q;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync_lvl;
        end
    end
`endif

    // Accepted-edge stage feeding both the tick outputs and the FSM.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_c;
            fall_q <= fall_c;
        end
    end

    // Monitor state and measurement registers.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            lost_q      <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            lost_q      <= lost_d;
            tick_rise_q <= tick_rise_d;
            tick_fall_q <= tick_fall_d;
        end
    end

    // Next state: a rise wins over a simultaneous timeout; falls only tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        period_d    = period_q;
        valid_d     = valid_q;
        tick_rise_d = rise_q;
        tick_fall_d = fall_q;

        if (rise_q) begin
            cnt_d = CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    state_d = ARMED;
                end
            end
            ARMED, LOCKED: begin
                if (rise_q) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    state_d  = LOCKED;
                end else if (cnt_q >= TIMEOUT) begin
                    valid_d  = 1'b0;
                    state_d  = LOST;
                end
            end
            LOST: begin
                if (rise_q) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        lost_d = (state_d == LOST);
    end

    assign mon.TICK_RISE    = tick_rise_q;
    assign mon.TICK_FALL    = tick_fall_q;
    assign mon.PERIOD       = period_q;
    assign mon.PERIOD_VALID = valid_q;
    assign mon.CLK_LOST     = lost_q;

endmodule
